// File: rtl/rxclk_aclk_word_assembler.sv
// rtl/rxclk_aclk_word_assembler.sv - nibble-to-word assembler with CE cadence lock and capture-error count
//
// Purpose: collects NIB_W-bit nibbles strobed by data_ce_i (already in the aclk domain)
// into NIB_W*NIBS-bit words. The CE cadence is checked against CE_PERIOD, and a
// three-state lock FSM gates dout_valid_o. The word boundary can be slipped by one
// nibble, and capture errors are counted in a saturating counter.
//
// Ports:
//   aclk_i         sole clock (rising edge)
//   aclk_resetn_i  asynchronous active-low reset
//   data_i         nibble from the transfer stage
//   data_ce_i      nibble-valid strobe
//   capture_err_i  per-cycle capture mismatch flag
//   slip_i         pulse: discard the next CE (shift the boundary by one nibble)
//   err_clr_i      pulse: clear err_count_o
//   dout_o         last completed word (first nibble at the MSBs)
//   dout_valid_o   one-cycle pulse: dout_o is new and was completed while locked
//   locked_o       high while the FSM is LOCKED
//   period_err_o   one-cycle pulse on a CE cadence violation
//   err_count_o    saturating capture-error count
module rxclk_aclk_word_assembler #(
    parameter int NIB_W      = 4,
    parameter int NIBS       = 8,
    parameter int CE_PERIOD  = 3,
    parameter int LOCK_COUNT = 16,
    parameter int CNT_W      = 16
) (
    input  logic                  aclk_i,
    input  logic                  aclk_resetn_i,
    input  logic [NIB_W-1:0]      data_i,
    input  logic                  data_ce_i,
    input  logic                  capture_err_i,
    input  logic                  slip_i,
    input  logic                  err_clr_i,
    output logic [NIB_W*NIBS-1:0] dout_o,
    output logic                  dout_valid_o,
    output logic                  locked_o,
    output logic                  period_err_o,
    output logic [CNT_W-1:0]      err_count_o
);

    localparam int W      = NIB_W * NIBS;
    localparam int GAP_W  = $clog2(CE_PERIOD + 2);
    localparam int IDX_W  = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

    localparam logic [GAP_W-1:0]  GAP_NOM   = GAP_W'(CE_PERIOD);
    localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(CE_PERIOD + 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NIBS - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_CHECK    = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [GOOD_W-1:0]   r_good;
    logic [GOOD_W-1:0]   w_good_nxt;
    logic [GAP_W-1:0]    r_gap;
    logic                r_first;
    logic                r_slip_armed;
    logic [IDX_W-1:0]    r_idx;
    logic [W-1:0]        r_asm;
    logic [W-1:0]        r_dout;
    logic                r_dout_valid;
    logic                r_period_err;
    logic [CNT_W-1:0]    r_err_cnt;

    logic                w_ce_early;
    logic                w_timeout;
    logic                w_period_evt;
    logic                w_err;
    logic                w_discard;
    logic                w_accept;
    logic [W-1:0]        w_asm_nxt;

    // A CE closing a short gap is flagged on arrival. A long gap is flagged once,
    // on the cycle it would have been good but no CE came; the late CE that
    // eventually ends it is then accepted silently.
    assign w_ce_early   = data_ce_i && !r_first && (r_gap < GAP_NOM);
    assign w_timeout    = !data_ce_i && !r_first && (r_gap == GAP_NOM);
    assign w_period_evt = w_ce_early || w_timeout;
    assign w_err        = w_period_evt || capture_err_i;

    // Slip discards the next CE, including one in the same cycle as the slip.
    assign w_discard = data_ce_i && (r_slip_armed || slip_i);
    assign w_accept  = data_ce_i && !w_discard;
    assign w_asm_nxt = (r_asm << NIB_W) | W'(data_i);

    // Gap counter saturates one past nominal so the timeout fires only once per gap.
    always_ff @(posedge aclk_i or negedge aclk_resetn_i) begin
        if (!aclk_resetn_i) begin
            r_gap   <= '0;
            r_first <= 1'b1;
        end else if (data_ce_i) begin
            r_gap   <= GAP_W'(1);
            r_first <= 1'b0;
        end else if (r_gap != GAP_MAX) begin
            r_gap   <= r_gap + GAP_W'(1);
        end
    end

    always_ff @(posedge aclk_i or negedge aclk_resetn_i) begin
        if (!aclk_resetn_i) begin
            r_state <= ST_UNLOCKED;
            r_good  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_good  <= w_good_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        case (r_state)
            ST_UNLOCKED: begin
                if (data_ce_i && !w_err) begin
                    w_state_nxt = ST_CHECK;
                    w_good_nxt  = '0;
                end
            end
            ST_CHECK: begin
                if (w_err) begin
                    w_state_nxt = ST_UNLOCKED;
                    w_good_nxt  = '0;
                end else if (data_ce_i) begin
                    if (r_good == GOOD_LAST) begin
                        w_state_nxt = ST_LOCKED;
                        w_good_nxt  = '0;
                    end else begin
                        w_good_nxt  = r_good + GOOD_W'(1);
                    end
                end
            end
            ST_LOCKED: begin
                if (w_err) begin
                    w_state_nxt = ST_UNLOCKED;
                    w_good_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = ST_UNLOCKED;
                w_good_nxt  = '0;
            end
        endcase
    end

    // Assembly runs regardless of lock; lock only qualifies dout_valid_o.
    always_ff @(posedge aclk_i or negedge aclk_resetn_i) begin
        if (!aclk_resetn_i) begin
            r_slip_armed <= 1'b0;
            r_idx        <= '0;
            r_asm        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;
            if (data_ce_i) begin
                r_slip_armed <= 1'b0;
            end else if (slip_i) begin
                r_slip_armed <= 1'b1;
            end
            if (w_accept) begin
                r_asm <= w_asm_nxt;
                if (r_idx == IDX_LAST) begin
                    r_idx        <= '0;
                    r_dout       <= w_asm_nxt;
                    r_dout_valid <= (r_state == ST_LOCKED) && !w_err;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
        end
    end

    // Clear wins over count, but an error in the clear cycle is still counted.
    always_ff @(posedge aclk_i or negedge aclk_resetn_i) begin
        if (!aclk_resetn_i) begin
            r_err_cnt    <= '0;
            r_period_err <= 1'b0;
        end else begin
            r_period_err <= w_period_evt;
            if (err_clr_i) begin
                r_err_cnt <= capture_err_i ? CNT_W'(1) : '0;
            end else if (capture_err_i && !(&r_err_cnt)) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    assign dout_o       = r_dout;
    assign dout_valid_o = r_dout_valid;
    assign locked_o     = (r_state == ST_LOCKED);
    assign period_err_o = r_period_err;
    assign err_count_o  = r_err_cnt;

endmodule

// File: tb/tb_rxclk_aclk_word_assembler.sv
// tb/tb_rxclk_aclk_word_assembler.sv - self-checking bench for rxclk_aclk_word_assembler
module tb_rxclk_aclk_word_assembler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  data;
    logic        ce;
    logic        cerr;
    logic        slip;
    logic        clr;
    logic [31:0] dout_o;
    logic        dout_valid_o;
    logic        locked_o;
    logic        period_err_o;
    logic [15:0] err_count_o;

    always #5 clk = ~clk;

    rxclk_aclk_word_assembler dut (
        .aclk_i        (clk),
        .aclk_resetn_i (rst_n),
        .data_i        (data),
        .data_ce_i     (ce),
        .capture_err_i (cerr),
        .slip_i        (slip),
        .err_clr_i     (clr),
        .dout_o        (dout_o),
        .dout_valid_o  (dout_valid_o),
        .locked_o      (locked_o),
        .period_err_o  (period_err_o),
        .err_count_o   (err_count_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: time of the last CE, lock progress, pending slip, nibbles collected.
    int          m_cyc;
    int          m_last;
    bit          m_first;
    int          m_lock;      // 0 unlocked, 1 checking, 2 locked
    int          m_good;
    bit          m_slip;
    int          m_cnt;
    logic [3:0]  m_q[$];
    logic [31:0] exp_dout;
    bit          exp_valid;
    bit          exp_locked;
    bit          exp_perr;

    int          n_perr;
    int          n_valid;
    logic [31:0] last_word;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_cyc = 0; m_last = 0; m_first = 1'b1;
        m_lock = 0; m_good = 0; m_slip = 1'b0; m_cnt = 0;
        m_q.delete();
        exp_dout = '0; exp_valid = 1'b0; exp_locked = 1'b0; exp_perr = 1'b0;
    endfunction

    function automatic void model_step();
        int          gap;
        bit          perr;
        bit          err;
        bit          was_locked;
        logic [31:0] word;
        gap  = m_cyc - m_last;
        perr = 1'b0;
        if (!m_first) begin
            if (ce && gap < 3) perr = 1'b1;
            if (!ce && gap == 3) perr = 1'b1;
        end
        err        = perr || cerr;
        was_locked = (m_lock == 2);
        exp_valid  = 1'b0;
        if (ce) begin
            if (m_slip || slip) begin
                m_slip = 1'b0;
            end else begin
                m_q.push_back(data);
                if (m_q.size() == 8) begin
                    word = '0;
                    for (int i = 0; i < 8; i++) word = (word << 4) | 32'(m_q[i]);
                    exp_dout  = word;
                    exp_valid = was_locked && !err;
                    m_q.delete();
                end
            end
        end else if (slip) begin
            m_slip = 1'b1;
        end
        if (err && m_lock != 0) begin
            m_lock = 0; m_good = 0;
        end else if (ce && !err) begin
            if (m_lock == 0) begin
                m_lock = 1; m_good = 0;
            end else if (m_lock == 1) begin
                m_good++;
                if (m_good == 16) m_lock = 2;
            end
        end
        exp_locked = (m_lock == 2);
        exp_perr   = perr;
        if (clr) m_cnt = cerr ? 1 : 0;
        else if (cerr && m_cnt < 65535) m_cnt++;
        if (ce) begin
            m_first = 1'b0;
            m_last  = m_cyc;
        end
        m_cyc++;
    endfunction

    always @(negedge clk) begin
        chk("dout", dout_o, exp_dout);
        chk("dout_valid", 32'(dout_valid_o), 32'(exp_valid));
        chk("locked", 32'(locked_o), 32'(exp_locked));
        chk("period_err", 32'(period_err_o), 32'(exp_perr));
        chk("err_count", 32'(err_count_o), 32'(m_cnt));
    end

    task automatic cyc(input bit c, input logic [3:0] d, input bit e, input bit s, input bit k);
        ce = c; data = d; cerr = e; slip = s; clr = k;
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        if (period_err_o) n_perr++;
        if (dout_valid_o) begin
            n_valid++;
            last_word = dout_o;
        end
    endtask

    // One nibble at nominal cadence: CE cycle then two idle cycles.
    task automatic send_nib(input logic [3:0] d, input bit e, input bit s_ce, input bit s_idle);
        cyc(1'b1, d, e, s_ce, 1'b0);
        cyc(1'b0, 4'h0, e, s_idle, 1'b0);
        cyc(1'b0, 4'h0, e, s_idle, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; data = '0; ce = 1'b0; cerr = 1'b0; slip = 1'b0; clr = 1'b0;
        n_perr = 0; n_valid = 0; last_word = '0;
        model_reset();
        repeat (3) cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("reset_locked", 32'(locked_o), 32'd0);
        chk("reset_dout", dout_o, 32'h0);
        chk("reset_errcnt", 32'(err_count_o), 32'd0);
        rst_n = 1'b1;
        repeat (2) cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

        // Lock acquisition: 17th CE locks, then words 0x01234567 are valid.
        for (int i = 0; i < 16; i++) send_nib(4'(i % 8), 1'b0, 1'b0, 1'b0);
        chk("not_locked_after_16", 32'(locked_o), 32'd0);
        send_nib(4'h0, 1'b0, 1'b0, 1'b0);
        chk("locked_after_17", 32'(locked_o), 32'd1);
        n_valid = 0;
        for (int i = 17; i < 32; i++) send_nib(4'(i % 8), 1'b0, 1'b0, 1'b0);
        chk("valid_words_locked", n_valid, 32'd2);
        chk("word_01234567", last_word, 32'h01234567);

        // Short gap while locked.
        n_perr = 0; n_valid = 0;
        cyc(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        send_nib(4'h1, 1'b0, 1'b0, 1'b0);
        chk("short_gap_perr", n_perr, 32'd1);
        chk("short_gap_unlock", 32'(locked_o), 32'd0);
        for (int i = 2; i < 8; i++) send_nib(4'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_nib(4'(i), 1'b0, 1'b0, 1'b0);
        chk("no_valid_relock", n_valid, 32'd0);
        for (int i = 0; i < 8; i++) send_nib(4'(i), 1'b0, 1'b0, 1'b0);
        chk("valid_after_relock", n_valid, 32'd1);
        chk("word_relock", last_word, 32'h01234567);

        // CE stalls for 6 cycles: one timeout pulse, late CE not flagged.
        n_perr = 0;
        repeat (4) cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        send_nib(4'h0, 1'b0, 1'b0, 1'b0);
        chk("timeout_once", n_perr, 32'd1);
        chk("timeout_unlock", 32'(locked_o), 32'd0);
        for (int i = 1; i < 8; i++) send_nib(4'(i), 1'b0, 1'b0, 1'b0);
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < 8; i++) send_nib(4'(i), 1'b0, 1'b0, (w == 1) && (i == 7));
        chk("relocked_before_slip", 32'(locked_o), 32'd1);

        // Slip (two idle-cycle slips collapse to one), then a slip coincident with CE.
        n_valid = 0;
        send_nib(4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) send_nib(4'(i), 1'b0, 1'b0, 1'b0);
        send_nib(4'h0, 1'b0, 1'b0, 1'b0);
        chk("slip_valid", n_valid, 32'd1);
        chk("slip_word", last_word, 32'h12345670);
        chk("slip_keeps_lock", 32'(locked_o), 32'd1);
        send_nib(4'h1, 1'b0, 1'b1, 1'b0);
        for (int i = 2; i < 8; i++) send_nib(4'(i), 1'b0, 1'b0, 1'b0);
        send_nib(4'h0, 1'b0, 1'b0, 1'b0);
        send_nib(4'h1, 1'b0, 1'b0, 1'b0);
        chk("slip_ce_word", last_word, 32'h23456701);

        // Capture errors: count, unlock, clear-with-error, saturation.
        send_nib(4'h2, 1'b1, 1'b0, 1'b0);
        chk("errcnt_3", 32'(err_count_o), 32'd3);
        chk("cerr_unlock", 32'(locked_o), 32'd0);
        cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
        chk("clr_with_err", 32'(err_count_o), 32'd1);
        repeat (65541) cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("errcnt_sat", 32'(err_count_o), 32'h0000FFFF);
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("errcnt_clr", 32'(err_count_o), 32'd0);

        // Reset mid-word.
        for (int i = 0; i < 5; i++) send_nib(4'(10 + i), 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_dout", dout_o, 32'h0);
        chk("rst_valid", 32'(dout_valid_o), 32'd0);
        chk("rst_locked", 32'(locked_o), 32'd0);
        chk("rst_perr", 32'(period_err_o), 32'd0);
        chk("rst_errcnt", 32'(err_count_o), 32'd0);
        model_reset();
        repeat (2) cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) send_nib(4'(8 + i), 1'b0, 1'b0, 1'b0);
        chk("word_after_reset", dout_o, 32'h89ABCDEF);
        repeat (3) cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
